// File: rtl/lcd_cmd_issuer.sv
// lcd_cmd_issuer: queues host LCD opcodes in a small FIFO and issues them one at a
// time to the LCD controller using its busy handshake. Issuing stops after the
// write-out opcode (0). The block then reports completion when lcd_done is seen.
// Optional build macro LCD_ACK_TIMEOUT_EN adds a 4-cycle ack timeout in WAIT_ACK.
// Without the macro, timeout_err is tied to 0.
module lcd_cmd_issuer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      host_cmd,
    input  logic            host_push,
    output logic            host_full,
    output logic [AW:0]     host_count,
    output logic            overflow,
    output logic [3:0]      lcd_cmd,
    output logic            lcd_cmd_valid,
    input  logic            lcd_busy,
    input  logic            lcd_done,
    output logic [CNT_W-1:0] issued_cnt,
    output logic            finished,
    output logic            timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ACK  = 3'd1,
        S_WAIT_FREE = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int unsigned OPC_W = 4;

    logic [OPC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             overflow_q;

    state_t           state_q;
    logic [OPC_W-1:0] lcd_cmd_q;
    logic             valid_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] issued_d;
    logic             finished_q;

    logic             full_c;
    logic             push_ok_c;
    logic             pop_c;
    logic [OPC_W-1:0] head_c;

    assign full_c    = (count_q == (AW+1)'(DEPTH));
    assign push_ok_c = host_push && !full_c;
    assign pop_c     = (state_q == S_IDLE) && (count_q != '0) && !lcd_busy;
    assign head_c    = mem_q[rd_ptr_q];

    // Next occupancy and saturating issue count
    always_comb begin
        count_d  = count_q;
        issued_d = issued_q;
        if (push_ok_c && !pop_c) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok_c && pop_c) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (issued_q != '1) begin
            issued_d = issued_q + CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= host_cmd;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a push into a full FIFO is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (host_push && full_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef LCD_ACK_TIMEOUT_EN
    logic [2:0] ack_cnt_q;
    logic       timeout_q;
`endif

    // Issue sequencer with registered controller-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lcd_cmd_q  <= '0;
            valid_q    <= 1'b0;
            issued_q   <= '0;
            finished_q <= 1'b0;
`ifdef LCD_ACK_TIMEOUT_EN
            ack_cnt_q  <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        lcd_cmd_q <= head_c;
                        valid_q   <= 1'b1;
                        issued_q  <= issued_d;
                        state_q   <= S_WAIT_ACK;
`ifdef LCD_ACK_TIMEOUT_EN
                        ack_cnt_q <= '0;
`endif
                    end
                end
                S_WAIT_ACK: begin
                    if (lcd_busy) begin
                        state_q <= (lcd_cmd_q == OPC_W'(0)) ? S_DRAIN : S_WAIT_FREE;
`ifdef LCD_ACK_TIMEOUT_EN
                    end else if (ack_cnt_q == 3'd3) begin
                        // Ack never came: flag it and move on without re-issuing
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 3'd1;
`endif
                    end
                end
                S_WAIT_FREE: begin
                    if (!lcd_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (lcd_done) begin
                        finished_q <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign host_full     = full_c;
    assign host_count    = count_q;
    assign overflow      = overflow_q;
    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = valid_q;
    assign issued_cnt    = issued_q;
    assign finished      = finished_q;
`ifdef LCD_ACK_TIMEOUT_EN
    assign timeout_err   = timeout_q;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Testbench for lcd_cmd_issuer: cycle vector table for FIFO fill/overflow/issue,
// plus hand-written sequences for busy gating, spacing, drain/done, reset, timeout.
module tb_lcd_cmd_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] host_cmd;
    logic       host_push;
    logic       host_full;
    logic [3:0] host_count;
    logic       overflow;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic [7:0] issued_cnt;
    logic       finished;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;
    int got_q[$];

    lcd_cmd_issuer dut (
        .clk          (clk),
        .reset        (reset),
        .host_cmd     (host_cmd),
        .host_push    (host_push),
        .host_full    (host_full),
        .host_count   (host_count),
        .overflow     (overflow),
        .lcd_cmd      (lcd_cmd),
        .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy     (lcd_busy),
        .lcd_done     (lcd_done),
        .issued_cnt   (issued_cnt),
        .finished     (finished),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [3:0] cmd;
        logic       busy;
        logic       e_valid;
        logic [3:0] e_cmd;
        logic [3:0] e_count;
        logic       e_full;
        logic       e_ovf;
        logic [7:0] e_issued;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic p, input logic [3:0] c, input logic b,
                                input logic ev, input logic [3:0] ec, input logic [3:0] en,
                                input logic ef, input logic eo, input logic [7:0] ei);
        vec_t v;
        v.push = p; v.cmd = c; v.busy = b; v.e_valid = ev; v.e_cmd = ec;
        v.e_count = en; v.e_full = ef; v.e_ovf = eo; v.e_issued = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; host_push = 1'b0; host_cmd = '0; lcd_busy = 1'b0; lcd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] c);
        host_cmd = c; host_push = 1'b1;
        @(posedge clk); #1;
        host_push = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            if (lcd_cmd_valid) break;
        end
        check("valid_seen", 32'(lcd_cmd_valid), 1);
    endtask

    // Controller model: busy for one cycle after each valid; records issued opcodes
    task automatic serve(input int n, input int max_cyc);
        int got = 0;
        int left = 0;
        int last = -100;
        got_q.delete();
        for (int c = 0; c < max_cyc && got < n; c++) begin
            @(posedge clk); #1;
            if (left > 0) begin
                left--;
                if (left == 0) lcd_busy = 1'b0;
            end
            if (lcd_cmd_valid) begin
                if (got > 0) check("issue_gap_ge3", 32'(c - last >= 3), 1);
                got_q.push_back(int'(lcd_cmd));
                last = c; got++;
                lcd_busy = 1'b1; left = 1;
            end
        end
        check("serve_count", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit saw;

        vt[0]  = mk(1, 1, 1, 0, 0, 1, 0, 0, 0);
        vt[1]  = mk(1, 2, 1, 0, 0, 2, 0, 0, 0);
        vt[2]  = mk(1, 3, 1, 0, 0, 3, 0, 0, 0);
        vt[3]  = mk(1, 4, 1, 0, 0, 4, 0, 0, 0);
        vt[4]  = mk(1, 5, 1, 0, 0, 5, 0, 0, 0);
        vt[5]  = mk(1, 6, 1, 0, 0, 6, 0, 0, 0);
        vt[6]  = mk(1, 7, 1, 0, 0, 7, 0, 0, 0);
        vt[7]  = mk(1, 8, 1, 0, 0, 8, 1, 0, 0);
        vt[8]  = mk(1, 9, 1, 0, 0, 8, 1, 1, 0);
        vt[9]  = mk(0, 0, 0, 1, 1, 7, 0, 1, 1);
        vt[10] = mk(0, 0, 0, 0, 1, 7, 0, 1, 1);
        vt[11] = mk(0, 0, 1, 0, 1, 7, 0, 1, 1);
        vt[12] = mk(1, 10, 1, 0, 1, 8, 1, 1, 1);
        vt[13] = mk(0, 0, 0, 0, 1, 8, 1, 1, 1);
        vt[14] = mk(1, 11, 0, 1, 2, 7, 0, 1, 2);

        // Reset values
        do_reset();
        check("rst_count", 32'(host_count), 0);
        check("rst_full", 32'(host_full), 0);
        check("rst_valid", 32'(lcd_cmd_valid), 0);
        check("rst_cmd", 32'(lcd_cmd), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_issued", 32'(issued_cnt), 0);
        check("rst_finished", 32'(finished), 0);
        check("rst_timeout", 32'(timeout_err), 0);

        // Vector table: fill to full, dropped push, issue, push-while-full-and-pop
        for (int i = 0; i < 15; i++) begin
            host_push = vt[i].push; host_cmd = vt[i].cmd; lcd_busy = vt[i].busy;
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 32'(lcd_cmd_valid), 32'(vt[i].e_valid));
            check($sformatf("vec%0d_cmd", i), 32'(lcd_cmd), 32'(vt[i].e_cmd));
            check($sformatf("vec%0d_count", i), 32'(host_count), 32'(vt[i].e_count));
            check($sformatf("vec%0d_full", i), 32'(host_full), 32'(vt[i].e_full));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vt[i].e_ovf));
            check($sformatf("vec%0d_issued", i), 32'(issued_cnt), 32'(vt[i].e_issued));
        end
        host_push = 1'b0;

        // Busy held after reset blocks issue; then 1,5,0 issued in order
        do_reset();
        lcd_busy = 1'b1;
        saw = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (lcd_cmd_valid) saw = 1'b1;
        end
        push(4'd1); if (lcd_cmd_valid) saw = 1'b1;
        push(4'd5); if (lcd_cmd_valid) saw = 1'b1;
        push(4'd0); if (lcd_cmd_valid) saw = 1'b1;
        check("busy_blocks_issue", 32'(saw), 0);
        check("t1_count3", 32'(host_count), 3);
        lcd_busy = 1'b0;
        serve(3, 60);
        if (got_q.size() == 3) begin
            check("t1_seq0", 32'(got_q[0]), 1);
            check("t1_seq1", 32'(got_q[1]), 5);
            check("t1_seq2", 32'(got_q[2]), 0);
        end
        check("t1_issued", 32'(issued_cnt), 3);

        // Write-out issued with busy stuck high: no more issues until/after done
        lcd_busy = 1'b1;
        push(4'd1);
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (lcd_cmd_valid) saw = 1'b1;
        end
        check("drain_no_issue", 32'(saw), 0);
        check("drain_finished0", 32'(finished), 0);
        lcd_done = 1'b1;
        @(posedge clk); #1;
        lcd_done = 1'b0;
        check("done_finished", 32'(finished), 1);
        lcd_busy = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (lcd_cmd_valid) saw = 1'b1;
        end
        check("done_no_issue", 32'(saw), 0);
        check("done_count1", 32'(host_count), 1);
        check("done_finished_sticky", 32'(finished), 1);

        // Spacing with one-cycle busy pulses: 2,3,4,7
        do_reset();
        lcd_busy = 1'b1;
        push(4'd2); push(4'd3); push(4'd4); push(4'd7);
        lcd_busy = 1'b0;
        serve(4, 80);
        if (got_q.size() == 4) begin
            check("t2_seq0", 32'(got_q[0]), 2);
            check("t2_seq1", 32'(got_q[1]), 3);
            check("t2_seq2", 32'(got_q[2]), 4);
            check("t2_seq3", 32'(got_q[3]), 7);
        end
        check("t2_empty", 32'(host_count), 0);
        check("t2_issued", 32'(issued_cnt), 4);
        lcd_busy = 1'b0;

        // Asynchronous reset while in WAIT_FREE with 3 queued
        do_reset();
        lcd_busy = 1'b1;
        push(4'd4); push(4'd5); push(4'd6); push(4'd7);
        lcd_busy = 1'b0;
        wait_valid(10);
        check("t5_cmd4", 32'(lcd_cmd), 4);
        lcd_busy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_count3", 32'(host_count), 3);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_count", 32'(host_count), 0);
        check("t5_rst_cmd", 32'(lcd_cmd), 0);
        check("t5_rst_issued", 32'(issued_cnt), 0);
        check("t5_rst_valid", 32'(lcd_cmd_valid), 0);
        @(posedge clk); #1 reset = 1'b0;
        lcd_busy = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (lcd_cmd_valid) saw = 1'b1;
        end
        check("t5_queue_lost", 32'(saw), 0);
        push(4'd9);
        wait_valid(3);
        check("t5_idle_issue", 32'(lcd_cmd), 9);
        #2 reset = 1'b1;
        #1;
        check("t5_valid_async_drop", 32'(lcd_cmd_valid), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Ack timeout behaviour
        do_reset();
        lcd_busy = 1'b1;
        push(4'd6); push(4'd8);
        lcd_busy = 1'b0;
        wait_valid(10);
        check("t6_cmd6", 32'(lcd_cmd), 6);
`ifdef LCD_ACK_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("t6_timeout_c%0d", k), 32'(timeout_err), 32'(k == 4));
            check($sformatf("t6_valid_c%0d", k), 32'(lcd_cmd_valid), 0);
        end
        @(posedge clk); #1;
        check("t6_next_valid", 32'(lcd_cmd_valid), 1);
        check("t6_next_cmd", 32'(lcd_cmd), 8);
        check("t6_issued", 32'(issued_cnt), 2);
`else
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (lcd_cmd_valid) saw = 1'b1;
        end
        check("t6_waits_forever", 32'(saw), 0);
        check("t6_timeout_tied0", 32'(timeout_err), 0);
        check("t6_count1", 32'(host_count), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
